seven_seg_display: RTL and testbench
====================================

// Module: seven_seg_display
// PURPOSE
//   Consumer end of the stopwatch counter's minutes/seconds interface: converts the
//   binary minutes/seconds values into BCD and drives a 4-digit, time-multiplexed,
//   active-low 7-segment display (MM.SS). In adjust mode it blinks the selected field.
//   Sits between the counter and the board pins; one display digit is lit per scan slot.
// PARAMETERS
//   REFRESH_DIV  100000    clk cycles per digit slot (1 kHz digit rate at 100 MHz), >=2
//   BLINK_DIV    25000000  clk cycles per blink-phase toggle (2 Hz blink at 100 MHz), >=2
// PORTS
//   clk      in   1  system clock; all state on rising edge
//   rst      in   1  synchronous, active-high reset
//   minutes  in   6  binary minutes from counter, 0..59 (60..63 decoded arithmetically)
//   seconds  in   6  binary seconds from counter, 0..59 (60..63 decoded arithmetically)
//   swADJ    in   1  1 = adjust mode, selected field blinks
//   swSEL    in   1  field select in adjust mode: 0 = minutes, 1 = seconds
//   an       out  4  digit anodes, active-low; an[0] = rightmost digit
//   seg      out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp       out  1  decimal point, active-low
// BEHAVIOUR
// - Reset (rst=1 at clk edge): an=4'b1111, seg=7'b1111111, dp=1, refresh count=0,
//   digit index=0, blink count=0, blink phase=0, snapshot min/sec=0. Reset mid-scan
//   aborts the frame; outputs blank on the following edge, no partial update kept.
// - Refresh counter: 0..REFRESH_DIV-1, wraps; tick asserted when count==REFRESH_DIV-1.
// - Digit index 2 bits: on tick, advances 0->1->2->3->0.
// - Snapshot: on tick with index==3 (frame end), snapMin<=minutes, snapSec<=seconds,
//   same edge index wraps to 0. Inputs ignored otherwise: no tearing within a frame.
// - Digit map: idx0 sec ones (an=1110), idx1 sec tens (1101), idx2 min ones (1011),
//   idx3 min tens (0111). tens = v/10, ones = v%10 (v=63 -> 6,3); no clamping.
// - Segment code (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
// - dp=0 only when idx==2 (point after minutes ones), else 1.
// - Blink: counter 0..BLINK_DIV-1; blink phase toggles on its wrap. Free-running,
//   independent of swADJ. Blank when swADJ=1 and phase=1 and current digit belongs
//   to selected field (swSEL=0: idx2/3; swSEL=1: idx0/1). Blank slot: an=1111,
//   seg=1111111, dp=1. swADJ/swSEL sampled every cycle (not snapshotted).
// - Latency: an/seg/dp are registered from idx, snapshot, blink state: they change
//   exactly 1 clk after the idx/snapshot/phase register changes. No combinational
//   path from any input to an output.
// - Exactly one an bit low at any time outside reset/blanking; never two.
// TESTING (bench uses REFRESH_DIV=4, BLINK_DIV=64)
//   1. Reset held 3 clks -> an=1111, seg=1111111, dp=1; release, minutes=0/seconds=0
//      -> an cycles 1110,1101,1011,0111 every 4 clks, seg=1000000 throughout.
//   2. minutes=12, seconds=34 applied, wait one frame -> idx0 seg=0011001(4),
//      idx1 0110000(3), idx2 0100100(2) with dp=0, idx3 1111001(1).
//   3. Change seconds 34->59 mid-frame (idx=1) -> remaining slots still show 34;
//      next frame shows idx0=0010000(9), idx1=0010010(5).
//   4. swADJ=1, swSEL=0, 12:34 -> while phase=1 slots idx2/idx3 give an=1111,
//      seg=1111111; idx0/idx1 unchanged; phase=0 all four digits lit; swADJ=0 none blank.
//   5. swADJ=1, swSEL=1 -> seconds digits blank in phase 1, minutes lit; seconds=63
//      with swADJ=0 -> idx1 shows 6 (0000010), idx0 shows 3 (0110000).
//   6. Assert rst at idx=2 mid-blink -> next edge all outputs blank, idx=0, phase=0,
//      snapshot 00; after release first frame shows 00.00 until frame-end capture.

Source files
------------

// File: rtl/seven_seg_display_if.sv
// Minutes/seconds bus from the stopwatch counter to the display driver.
interface seven_seg_display_if;
    logic [5:0] minutes;
    logic [5:0] seconds;

    modport master (output minutes, output seconds);
    modport slave  (input  minutes, input  seconds);
endinterface

// File: rtl/seven_seg_display.sv
// Multiplexed 4-digit active-low 7-segment driver showing MM.SS, with per-field blink in adjust mode.
module seven_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    seven_seg_display_if.slave        bus,
    input  logic                      swADJ,
    input  logic                      swSEL,
    output logic [3:0]                an,
    output logic [6:0]                seg,
    output logic                      dp
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_t;

    digit_t        idx, idx_next;
    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [5:0]    snap_min, snap_sec;
    logic          tick;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
    logic [3:0] digit;
    logic       field_blank;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    assign tick = (refresh_cnt == REFRESH_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= DIG_SEC_ONES;
        end else begin
            idx <= idx_next;
        end
    end

    always_comb begin
        idx_next = idx;
        if (tick) begin
            case (idx)
                DIG_SEC_ONES: idx_next = DIG_SEC_TENS;
                DIG_SEC_TENS: idx_next = DIG_MIN_ONES;
                DIG_MIN_ONES: idx_next = DIG_MIN_TENS;
                default:      idx_next = DIG_SEC_ONES;
            endcase
        end
    end

    // Snapshot only at frame end so a whole frame always shows one coherent time.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_min    <= '0;
            snap_sec    <= '0;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (tick && idx == DIG_MIN_TENS) begin
                snap_min <= bus.minutes;
                snap_sec <= bus.seconds;
            end
        end
    end

    assign sec_tens = 4'(snap_sec / 6'd10);
    assign sec_ones = 4'(snap_sec - 6'(sec_tens) * 6'd10);
    assign min_tens = 4'(snap_min / 6'd10);
    assign min_ones = 4'(snap_min - 6'(min_tens) * 6'd10);

    always_comb begin
        digit       = sec_ones;
        an_next     = 4'b1111;
        seg_next    = '1;
        dp_next     = 1'b1;
        field_blank = swADJ && blink_phase &&
                      (swSEL ? (idx == DIG_SEC_ONES || idx == DIG_SEC_TENS)
                             : (idx == DIG_MIN_ONES || idx == DIG_MIN_TENS));
        case (idx)
            DIG_SEC_ONES: digit = sec_ones;
            DIG_SEC_TENS: digit = sec_tens;
            DIG_MIN_ONES: digit = min_ones;
            default:      digit = min_tens;
        endcase
        if (!field_blank) begin
            case (idx)
                DIG_SEC_ONES: an_next = 4'b1110;
                DIG_SEC_TENS: an_next = 4'b1101;
                DIG_MIN_ONES: an_next = 4'b1011;
                default:      an_next = 4'b0111;
            endcase
            seg_next = seg_code(digit);
            dp_next  = (idx != DIG_MIN_ONES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end
endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display: scan order, digit decode, frame snapshot, blink and reset.
module tb_seven_seg_display;
    logic       clk = 1'b0;
    logic       rst;
    logic       swADJ, swSEL;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10];
    logic [3:0] an_tab  [4];

    seven_seg_display_if bus ();

    seven_seg_display #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .swADJ (swADJ),
        .swSEL (swSEL),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One scan slot lasts 4 clocks; outputs are checked after every edge of the slot.
    task automatic check_slot(input string tag, input int slot, input logic blank, input int dig);
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        ean  = blank ? 4'b1111 : an_tab[slot];
        eseg = blank ? 7'b1111111 : seg_tab[dig];
        edp  = (blank || slot != 2) ? 1'b1 : 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s s%0d an", tag, slot), {4'b0, an}, {4'b0, ean});
            chk($sformatf("%s s%0d seg", tag, slot), {1'b0, seg}, {1'b0, eseg});
            chk($sformatf("%s s%0d dp", tag, slot), {7'b0, dp}, {7'b0, edp});
        end
    endtask

    task automatic check_frame(input string tag, input int mt, input int mo, input int st, input int so,
                               input logic bmin, input logic bsec, input int mid_sec);
        check_slot(tag, 0, bsec, so);
        if (mid_sec >= 0) bus.seconds = 6'(mid_sec);
        check_slot(tag, 1, bsec, st);
        check_slot(tag, 2, bmin, mo);
        check_slot(tag, 3, bmin, mt);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

        rst = 1'b1; swADJ = 1'b0; swSEL = 1'b0;
        bus.minutes = 6'd0; bus.seconds = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset an", {4'b0, an}, 8'h0F);
        chk("reset seg", {1'b0, seg}, 8'h7F);
        chk("reset dp", {7'b0, dp}, 8'h01);
        rst = 1'b0;

        // New inputs land in the snapshot only at the end of frame 0.
        bus.minutes = 6'd12; bus.seconds = 6'd34;
        check_frame("f0 00:00", 0, 0, 0, 0, 1'b0, 1'b0, -1);
        check_frame("f1 12:34", 1, 2, 3, 4, 1'b0, 1'b0, -1);
        check_frame("f2 tear", 1, 2, 3, 4, 1'b0, 1'b0, 59);
        check_frame("f3 12:59", 1, 2, 5, 9, 1'b0, 1'b0, 34);

        swADJ = 1'b1; swSEL = 1'b0;
        check_frame("f4 blink min", 1, 2, 3, 4, 1'b1, 1'b0, -1);
        swSEL = 1'b1;
        check_frame("f5 blink sec", 1, 2, 3, 4, 1'b0, 1'b1, 63);
        swADJ = 1'b0;
        check_frame("f6 12:63", 1, 2, 6, 3, 1'b0, 1'b0, -1);
        swADJ = 1'b1; swSEL = 1'b1;
        check_frame("f7 blink sec", 1, 2, 6, 3, 1'b0, 1'b1, 34);
        swSEL = 1'b0;
        check_frame("f8 phase0", 1, 2, 3, 4, 1'b0, 1'b0, -1);
        repeat (48) @(posedge clk);
        #1;

        // Frame 12 is back in blink phase 1; reset lands while idx==2.
        check_slot("f12 pre-rst", 0, 1'b0, 4);
        check_slot("f12 pre-rst", 1, 1'b0, 3);
        rst = 1'b1;
        bus.minutes = 6'd45;
        @(posedge clk);
        #1;
        chk("mid reset an", {4'b0, an}, 8'h0F);
        chk("mid reset seg", {1'b0, seg}, 8'h7F);
        chk("mid reset dp", {7'b0, dp}, 8'h01);
        rst = 1'b0;
        check_frame("post-rst 00:00", 0, 0, 0, 0, 1'b0, 1'b0, -1);
        check_frame("post-rst 45:34", 4, 5, 3, 4, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
